// File: rtl/dma_channel_sequencer_if.sv
// System-bus side of the DMA channel sequencer: request/hold handshake,
// acknowledges, transfer address and command strobes.
interface dma_channel_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16
);
  logic [NUM_CH-1:0] dreq;
  logic              hlda;
  logic              ready;
  logic              eop_n_in;
  logic              hrq;
  logic              aen;
  logic              adstb;
  logic [NUM_CH-1:0] dack;
  logic [ADDR_W-1:0] addr;
  logic              ior_n;
  logic              iow_n;
  logic              memr_n;
  logic              memw_n;
  logic              eop_n_out;

  modport master (
    input  dreq, hlda, ready, eop_n_in,
    output hrq, aen, adstb, dack, addr, ior_n, iow_n, memr_n, memw_n, eop_n_out
  );

  modport slave (
    output dreq, hlda, ready, eop_n_in,
    input  hrq, aen, adstb, dack, addr, ior_n, iow_n, memr_n, memw_n, eop_n_out
  );
endinterface

// File: rtl/dma_channel_sequencer.sv
// Multi-channel DMA timing-and-control sequencer: arbitration, per-channel
// address/count registers, single/block/demand transfers with wait states and TC/EOP.
module dma_channel_sequencer #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dma_channel_sequencer_if.master bus,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [2*NUM_CH-1:0]     xfer_type_i,
  input  logic [2*NUM_CH-1:0]     xfer_mode_i,
  input  logic [NUM_CH-1:0]       auto_init_i,
  input  logic [NUM_CH-1:0]       addr_dec_i,
  input  logic                    rot_prio_i,
  input  logic                    wr_en_i,
  input  logic [2:0]              wr_ch_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [CNT_W-1:0]        wr_cnt_i,
  input  logic                    clr_tc_i,
  output logic [NUM_CH-1:0]       tc_status_o,
  output logic                    busy_o
);
  // state | meaning
  // IDLE  | bus released, register writes accepted, arbitration
  // REQ   | hold requested, waiting for HLDA
  // S1    | address phase, ADSTB high
  // S2    | command strobes active
  // SW    | wait state while READY is low
  // S4    | strobes released, address/count update, terminal check
  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [5:0] ST_REQ  = 6'b000010;
  localparam logic [5:0] ST_S1   = 6'b000100;
  localparam logic [5:0] ST_S2   = 6'b001000;
  localparam logic [5:0] ST_SW   = 6'b010000;
  localparam logic [5:0] ST_S4   = 6'b100000;

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [5:0]        state_q, state_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              eop_seen_q, eop_seen_d;
  logic [NUM_CH-1:0] tc_q, tc_d;
  logic [ADDR_W-1:0] base_addr_q [NUM_CH];
  logic [ADDR_W-1:0] base_addr_d [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_q  [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_d  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  base_cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] elig;
  logic              arb_found;
  logic [CH_W-1:0]   arb_cand;
  logic [CH_W-1:0]   arb_win;
  logic [1:0]        act_type;
  logic [1:0]        act_mode;
  logic              terminal;

  assign act_type = xfer_type_i[{act_q, 1'b0} +: 2];
  assign act_mode = xfer_mode_i[{act_q, 1'b0} +: 2];
  assign terminal = (cur_cnt_q[act_q] == '0) || eop_seen_q;

  // Walk channels from the current highest priority; first eligible one wins.
  always_comb begin
    elig      = bus.dreq & ch_en_i & ~tc_q;
    arb_found = 1'b0;
    arb_cand  = '0;
    arb_win   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      arb_cand = CH_W'(rot_prio_i ? (int'(ptr_q) + i) % NUM_CH : i);
      if (!arb_found && elig[arb_cand]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    ptr_d       = ptr_q;
    eop_seen_d  = eop_seen_q;
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_cnt_d   = cur_cnt_q;
    // a TC set later in this block overrides the clear
    tc_d        = clr_tc_i ? '0 : tc_q;

    case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_en_i && wr_ch_i == 3'(i)) begin
            base_addr_d[i] = wr_addr_i;
            cur_addr_d[i]  = wr_addr_i;
            base_cnt_d[i]  = wr_cnt_i;
            cur_cnt_d[i]   = wr_cnt_i;
          end
        end
        if (arb_found) begin
          act_d   = arb_win;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.hlda) state_d = ST_S1;
      end
      ST_S1: begin
        eop_seen_d = 1'b0;
        state_d    = ST_S2;
      end
      ST_S2, ST_SW: begin
        if (!bus.eop_n_in) eop_seen_d = 1'b1;
        state_d = bus.ready ? ST_S4 : ST_SW;
      end
      ST_S4: begin
        cur_addr_d[act_q] = addr_dec_i[act_q] ? cur_addr_q[act_q] - 1'b1
                                              : cur_addr_q[act_q] + 1'b1;
        if (terminal) begin
          tc_d[act_q] = 1'b1;
          if (auto_init_i[act_q]) begin
            cur_addr_d[act_q] = base_addr_q[act_q];
            cur_cnt_d[act_q]  = base_cnt_q[act_q];
          end
        end else begin
          cur_cnt_d[act_q] = cur_cnt_q[act_q] - 1'b1;
        end

        if (terminal || !bus.hlda || act_mode[0]) begin
          state_d = ST_IDLE;
        end else if (act_mode == 2'b10) begin
          state_d = ST_S1;
        end else begin
          state_d = bus.dreq[act_q] ? ST_S1 : ST_IDLE;
        end

        if (state_d == ST_IDLE && rot_prio_i) begin
          ptr_d = (act_q == CH_W'(NUM_CH - 1)) ? '0 : act_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      ptr_q      <= '0;
      eop_seen_q <= 1'b0;
      tc_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr_q[i] <= '0;
        cur_addr_q[i]  <= '0;
        base_cnt_q[i]  <= '0;
        cur_cnt_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      ptr_q       <= ptr_d;
      eop_seen_q  <= eop_seen_d;
      tc_q        <= tc_d;
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_cnt_q   <= cur_cnt_d;
    end
  end

  logic st_s1, st_strobe, st_s4, in_xfer;

  assign st_s1     = (state_q == ST_S1);
  assign st_strobe = (state_q == ST_S2) || (state_q == ST_SW);
  assign st_s4     = (state_q == ST_S4);
  assign in_xfer   = st_s1 | st_strobe | st_s4;

  assign busy_o        = (state_q != ST_IDLE);
  assign bus.hrq       = busy_o;
  assign bus.aen       = in_xfer;
  assign bus.adstb     = st_s1;
  assign bus.addr      = in_xfer ? cur_addr_q[act_q] : '0;
  assign bus.ior_n     = !(st_strobe && act_type == 2'b01);
  assign bus.memw_n    = !(st_strobe && act_type == 2'b01);
  assign bus.iow_n     = !(st_strobe && act_type == 2'b10);
  assign bus.memr_n    = !(st_strobe && act_type == 2'b10);
  assign bus.eop_n_out = !(st_s4 && terminal);
  assign tc_status_o   = tc_q;

  always_comb begin
    bus.dack = '0;
    if (in_xfer) bus.dack[act_q] = 1'b1;
  end
endmodule

// File: tb/tb_dma_channel_sequencer.sv
// Directed bench for dma_channel_sequencer: reset, single/block/demand
// transfers, wait states, arbitration order, EOP and autoinitialisation.
module tb_dma_channel_sequencer;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_channel_sequencer_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  logic [3:0]  ch_en, auto_init, addr_dec, tc_status;
  logic [7:0]  xfer_type, xfer_mode;
  logic        rot_prio, wr_en, clr_tc, busy;
  logic [2:0]  wr_ch;
  logic [15:0] wr_addr, wr_cnt;

  dma_channel_sequencer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ch_en_i     (ch_en),
    .xfer_type_i (xfer_type),
    .xfer_mode_i (xfer_mode),
    .auto_init_i (auto_init),
    .addr_dec_i  (addr_dec),
    .rot_prio_i  (rot_prio),
    .wr_en_i     (wr_en),
    .wr_ch_i     (wr_ch),
    .wr_addr_i   (wr_addr),
    .wr_cnt_i    (wr_cnt),
    .clr_tc_i    (clr_tc),
    .tc_status_o (tc_status),
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;

  // {hrq, aen, adstb, dack[3:0], ior_n, iow_n, memr_n, memw_n, eop_n_out, busy}
  function automatic logic [12:0] ov();
    return {bus.hrq, bus.aen, bus.adstb, bus.dack, bus.ior_n, bus.iow_n,
            bus.memr_n, bus.memw_n, bus.eop_n_out, busy};
  endfunction

  function automatic logic [12:0] ev(input logic [2:0] hab, input logic [3:0] dk,
                                     input logic [3:0] st, input logic eop);
    return {hab, dk, st, eop, hab[2]};
  endfunction

  localparam logic [12:0] V_IDLE = {3'b000, 4'b0000, 4'b1111, 1'b1, 1'b0};
  localparam logic [12:0] V_REQ  = {3'b100, 4'b0000, 4'b1111, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [12:0] v, input logic [15:0] a);
    step();
    chk(tag, 32'(ov()), 32'(v));
    chk({tag, "_addr"}, 32'(bus.addr), 32'(a));
  endtask

  task automatic program_ch(input logic [2:0] ch, input logic [15:0] a, input logic [15:0] c);
    wr_en = 1'b1; wr_ch = ch; wr_addr = a; wr_cnt = c;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_s1(input string tag, output logic [3:0] dk, output logic [15:0] a);
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.adstb) break;
    end
    chk({tag, "_s1_seen"}, 32'(bus.adstb), 32'd1);
    dk = bus.dack;
    a  = bus.addr;
  endtask

  logic [3:0]  dk;
  logic [15:0] a;
  logic [3:0]  rot_exp [5];
  int          nwords;

  initial begin
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.dreq = '0; bus.hlda = 1'b0; bus.ready = 1'b1; bus.eop_n_in = 1'b1;
    ch_en = 4'hF; xfer_type = '0; xfer_mode = 8'h55; auto_init = '0; addr_dec = '0;
    rot_prio = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_cnt = '0; clr_tc = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_outputs", 32'(ov()), 32'(V_IDLE));

    // Reset asserted while stalled in SW
    program_ch(3'd0, 16'h1234, 16'd0);
    xfer_type[1:0] = 2'b01; bus.hlda = 1'b1; bus.ready = 1'b0; bus.dreq = 4'b0001;
    cyc("t1_req", V_REQ, 16'h0);
    cyc("t1_s1", ev(3'b111, 4'b0001, 4'b1111, 1'b1), 16'h1234);
    cyc("t1_s2", ev(3'b110, 4'b0001, 4'b0110, 1'b1), 16'h1234);
    cyc("t1_sw", ev(3'b110, 4'b0001, 4'b0110, 1'b1), 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_outputs", 32'(ov()), 32'(V_IDLE));
    chk("t1_rst_addr", 32'(bus.addr), 32'h0);
    chk("t1_rst_tc", 32'(tc_status), 32'h0);
    bus.dreq = '0; bus.ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("t1_after_release", 32'(ov()), 32'(V_IDLE));

    // ch2 single, count 0, IO->mem
    bus.hlda = 1'b0;
    program_ch(3'd2, 16'h00FF, 16'd0);
    xfer_type[5:4] = 2'b01;
    bus.dreq = 4'b0100;
    cyc("t2_hrq", V_REQ, 16'h0);
    cyc("t2_wait_hlda", V_REQ, 16'h0);
    bus.hlda = 1'b1;
    cyc("t2_s1", ev(3'b111, 4'b0100, 4'b1111, 1'b1), 16'h00FF);
    cyc("t2_s2", ev(3'b110, 4'b0100, 4'b0110, 1'b1), 16'h00FF);
    cyc("t2_s4", ev(3'b110, 4'b0100, 4'b1111, 1'b0), 16'h00FF);
    cyc("t2_idle", V_IDLE, 16'h0);
    chk("t2_tc", 32'(tc_status), 32'b0100);
    cyc("t2_tc_blocks", V_IDLE, 16'h0);

    // ch0 block, count 2, wrap from 0xFFFF, 2 wait states on word 2
    bus.dreq = '0;
    program_ch(3'd0, 16'hFFFF, 16'd2);
    xfer_type[1:0] = 2'b10; xfer_mode[1:0] = 2'b10;
    bus.dreq = 4'b0001;
    cyc("t3_req", V_REQ, 16'h0);
    cyc("t3_w1_s1", ev(3'b111, 4'b0001, 4'b1111, 1'b1), 16'hFFFF);
    cyc("t3_w1_s2", ev(3'b110, 4'b0001, 4'b1001, 1'b1), 16'hFFFF);
    cyc("t3_w1_s4", ev(3'b110, 4'b0001, 4'b1111, 1'b1), 16'hFFFF);
    cyc("t3_w2_s1", ev(3'b111, 4'b0001, 4'b1111, 1'b1), 16'h0000);
    cyc("t3_w2_s2", ev(3'b110, 4'b0001, 4'b1001, 1'b1), 16'h0000);
    bus.ready = 1'b0;
    cyc("t3_w2_sw1", ev(3'b110, 4'b0001, 4'b1001, 1'b1), 16'h0000);
    cyc("t3_w2_sw2", ev(3'b110, 4'b0001, 4'b1001, 1'b1), 16'h0000);
    bus.ready = 1'b1;
    cyc("t3_w2_s4", ev(3'b110, 4'b0001, 4'b1111, 1'b1), 16'h0000);
    cyc("t3_w3_s1", ev(3'b111, 4'b0001, 4'b1111, 1'b1), 16'h0001);
    cyc("t3_w3_s2", ev(3'b110, 4'b0001, 4'b1001, 1'b1), 16'h0001);
    cyc("t3_w3_s4", ev(3'b110, 4'b0001, 4'b1111, 1'b0), 16'h0001);
    cyc("t3_idle", V_IDLE, 16'h0);
    chk("t3_tc", 32'(tc_status), 32'b0101);

    // Rotating then fixed priority with all four requesting
    bus.dreq = '0;
    do_reset();
    for (int i = 0; i < 4; i++) program_ch(3'(i), 16'(16'h1000 * i), 16'd100);
    xfer_type = '0; xfer_mode = 8'h55; rot_prio = 1'b1; bus.dreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_s1("t4_rot", dk, a);
      chk($sformatf("t4_rot_order%0d", k), 32'(dk), 32'(rot_exp[k]));
    end
    rot_prio = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_s1("t4_fix", dk, a);
      chk($sformatf("t4_fix_order%0d", k), 32'(dk), 32'b0001);
      step(); step(); step();
      chk($sformatf("t4_hrq_drop%0d", k), 32'(bus.hrq), 32'd0);
    end

    // ch1 demand, DREQ dropped after 3 words, then resumed to TC
    bus.dreq = '0;
    do_reset();
    program_ch(3'd1, 16'h0100, 16'd10);
    xfer_mode[3:2] = 2'b00; xfer_type[3:2] = 2'b01;
    bus.dreq = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      wait_s1("t5_word", dk, a);
      chk($sformatf("t5_addr%0d", k), 32'(a), 32'(16'h0100 + k));
      if (k == 2) bus.dreq = '0;
    end
    step(); step(); step();
    chk("t5_idle", 32'(ov()), 32'(V_IDLE));
    chk("t5_no_tc", 32'(tc_status), 32'h0);
    bus.dreq = 4'b0010;
    wait_s1("t5_resume", dk, a);
    chk("t5_resume_addr", 32'(a), 32'h0103);
    nwords = 1;
    for (int n = 0; n < 100; n++) begin
      step();
      if (!bus.eop_n_out) break;
      if (bus.adstb) nwords++;
    end
    chk("t5_eop_seen", 32'(bus.eop_n_out), 32'd0);
    chk("t5_remaining_words", 32'(nwords), 32'd8);
    chk("t5_last_addr", 32'(bus.addr), 32'h010A);
    step();
    chk("t5_tc", 32'(tc_status), 32'b0010);

    // ch3 autoinit with external EOP on the first word
    bus.dreq = '0;
    step();
    program_ch(3'd3, 16'h0300, 16'd1);
    auto_init[3] = 1'b1; xfer_mode[7:6] = 2'b01; xfer_type[7:6] = 2'b10;
    bus.dreq = 4'b1000;
    wait_s1("t6_first", dk, a);
    chk("t6_first_addr", 32'(a), 32'h0300);
    wr_en = 1'b1; wr_ch = 3'd3; wr_addr = 16'hAAAA; wr_cnt = 16'd0;
    step();
    wr_en = 1'b0; bus.eop_n_in = 1'b0;
    chk("t6_s2", 32'(ov()), 32'(ev(3'b110, 4'b1000, 4'b1001, 1'b1)));
    step();
    bus.eop_n_in = 1'b1;
    chk("t6_s4_eop", 32'(ov()), 32'(ev(3'b110, 4'b1000, 4'b1111, 1'b0)));
    clr_tc = 1'b1;
    step();
    clr_tc = 1'b0;
    chk("t6_set_beats_clr", 32'(tc_status), 32'b1000);
    step();
    chk("t6_tc_blocks", 32'(ov()), 32'(V_IDLE));
    clr_tc = 1'b1;
    step();
    clr_tc = 1'b0;
    chk("t6_tc_cleared", 32'(tc_status), 32'h0);
    wait_s1("t6_again", dk, a);
    chk("t6_again_dack", 32'(dk), 32'b1000);
    chk("t6_reload_addr", 32'(a), 32'h0300);
    step(); step();
    chk("t6_reload_cnt", 32'(bus.eop_n_out), 32'd1);
    bus.dreq = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_channel_sequencer.md
# dma_channel_sequencer

Parametrised successor to the DMA timing-and-control state machine. It arbitrates among `NUM_CH` DMA request lines and holds per-channel base/current address and word-count registers. It runs single, block or demand transfers with READY wait states, autoinitialisation and terminal-count/EOP handling, and drives the system-bus handshake and command strobes. It sits between the register-programming logic and the top-level bus tri-state drivers.

## Interface
- `NUM_CH`, default 4: number of DMA channels (1-8).
- `ADDR_W`, default 16: address register width.
- `CNT_W`, default 16: word-count register width.
- `CLK` in 1: single clock; all state changes on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `DREQ` in `NUM_CH`: channel requests, active high.
- `HLDA` in 1: hold acknowledge from the CPU.
- `READY` in 1: low inserts wait states.
- `EOP_N_IN` in 1: external end-of-process, active low.
- `ch_en` in `NUM_CH`: per-channel enable mask.
- `xfer_type` in 2*`NUM_CH`: per channel; 00 verify, 01 write (IO→mem), 10 read (mem→IO), 11 treated as verify.
- `xfer_mode` in 2*`NUM_CH`: per channel; 00 demand, 01 single, 10 block, 11 treated as single.
- `auto_init` in `NUM_CH`: reload current registers from base at terminal count.
- `addr_dec` in `NUM_CH`: decrement address instead of increment.
- `rot_prio` in 1: 0 fixed priority (ch0 highest), 1 rotating.
- `wr_en` in 1, `wr_ch` in 3, `wr_addr` in `ADDR_W`, `wr_cnt` in `CNT_W`: program base and current registers of `wr_ch`.
- `clr_tc` in 1: clear all `TC_STATUS` bits.
- `HRQ` out 1: hold request.
- `AEN` out 1: address enable.
- `ADSTB` out 1: address strobe.
- `DACK` out `NUM_CH`: one-hot acknowledge.
- `ADDR` out `ADDR_W`: current transfer address.
- `IOR_N`, `IOW_N`, `MEMR_N`, `MEMW_N` out 1 each: command strobes, driven (tri-stating happens at top level).
- `EOP_N_OUT` out 1: terminal-count pulse, active low.
- `TC_STATUS` out `NUM_CH`: sticky terminal-count flags.
- `BUSY` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, REQ, S1, S2, SW, S4. One-hot encoded. All outputs decoded from registered state and active-channel registers.
- Reset (any state) gives:
  - state IDLE;
  - `HRQ`/`AEN`/`ADSTB`/`BUSY` = 0, `DACK` = 0, `ADDR` = 0;
  - strobes = 1, `EOP_N_OUT` = 1;
  - `TC_STATUS` = 0 and all address/count registers = 0;
  - rotating priority pointer = ch0 highest.
- A channel is eligible when `DREQ[i] & ch_en[i] & !TC_STATUS[i]`.
- IDLE:
  - `wr_en` loads base and current address/count of `wr_ch`. Writes are ignored in any other state and when `wr_ch` ≥ `NUM_CH`.
  - If any channel is eligible, latch the highest-priority one as the active channel and go to REQ. `wr_en` and a new request in the same cycle: the write takes effect and arbitration uses the pre-write values.
- REQ: `HRQ`=1. Wait for `HLDA`=1, then go to S1.
- S1:
  - `HRQ`, `AEN`, `ADSTB` = 1; `DACK[active]` = 1.
  - `ADDR` = current address. Go to S2.
- S2:
  - `HRQ`, `AEN`, `DACK` held.
  - Strobes per `xfer_type`: 01 → `IOR_N`=`MEMW_N`=0; 10 → `IOW_N`=`MEMR_N`=0; verify → none.
  - `READY`=0 goes to SW, otherwise S4.
- SW: same outputs as S2. Leave for S4 on the first cycle `READY`=1.
- S4:
  - Strobes deasserted; `AEN`/`DACK` held.
  - Address ±1, wrapping modulo 2^`ADDR_W`.
  - If current count == 0 or `EOP_N_IN` was sampled low in S2/SW: terminal. Otherwise count −1.
- On terminal:
  - `EOP_N_OUT`=0 for the S4 cycle and `TC_STATUS[active]` is set.
  - If `auto_init`, current registers reload from base and the status bit is still set.
  - A programmed count of N gives N+1 transfers.
- Next state after S4:
  - Terminal → IDLE.
  - Single → IDLE; `HRQ` drops for at least one cycle.
  - Block → S1.
  - Demand → S1 if `DREQ[active]`, otherwise IDLE.
  - Any mode with `HLDA`=0 → IDLE.
- Rotating priority: on leaving for IDLE, the serviced channel becomes lowest priority.
- `clr_tc` clears all `TC_STATUS` bits. A same-cycle set takes priority over the clear.

## Timing
- A request sampled in IDLE at cycle t gives `HRQ`=1 at t+1.
- `HLDA` sampled high at cycle u gives S1 at u+1.
- Zero-wait transfer: S1, S2, S4 = 3 cycles. Each `READY`=0 cycle sampled in S2/SW adds one SW cycle.
- Block throughput is 3 cycles per word with no IDLE between words.
- `ADDR` is stable from S1 through S4. The updated address appears at the next S1.
- `ADSTB` is asserted in S1 only. `EOP_N_OUT` is a 1-cycle pulse aligned with S4.
- Deasserting `DREQ` after grant does not cancel the in-progress transfer.

## Test plan
- Reset mid-SW (asserted with `READY`=0) → all outputs at reset values in the same cycle; after release, IDLE with no `HRQ`.
- ch2 single, count 0, addr 0x00FF, `xfer_type` 01 → `HRQ` at t+1, then S1/S2/S4. `IOR_N`/`MEMW_N` low 1 cycle, `ADDR`=0x00FF, `EOP_N_OUT` pulse, `TC_STATUS`=0100, back to IDLE.
- ch0 block, count 2, addr 0xFFFF, `addr_dec`=0, `READY` low 2 cycles on the second word → 3 transfers at 0xFFFF, 0x0000, 0x0001 with 2 SW cycles on the second; `EOP_N_OUT` on the third S4 only.
- `DREQ`=1111 held, `rot_prio`=1, all single with large counts → service order 0,1,2,3,0. With `rot_prio`=0 → 0,0,0.
- ch1 demand, count 10, `DREQ` dropped after 3 words → 3 transfers, then IDLE. Current count = 7 with no TC; a later `DREQ` resumes at the 4th address.
- ch3 `auto_init`, base count 1, `EOP_N_IN` low in the first S2 → terminal at the first S4. Current regs reload to base, `TC_STATUS[3]` set; `clr_tc` re-enables ch3.
